// File: rtl/mult_share_pkg.sv
// Shared encodings for the two-requester multiplier arbiter: FSM state codes,
// grant identifiers and the round-robin pick.
package mult_share_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic GNT0 = 1'b0;
  localparam logic GNT1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_MUL  = MUL,
    ST_DONE = DONE
  } state_e;

  // On contention the requester that did not win last time is chosen.
  function automatic logic pick_grant(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    else if (r1)   return GNT1;
    else           return GNT0;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_mul.sv
// Unsigned combinational multiplier producing the full 2n-bit product.
module multiplyOperator #(
  parameter int n = 4
) (
  input  logic [n-1:0]   A,
  input  logic [n-1:0]   B,
  output logic [2*n-1:0] Z
);

  assign Z = {{n{1'b0}}, A} * {{n{1'b0}}, B};

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one multiplier between two requesters; operands are
// latched at grant, the product is captured one cycle later and announced by done.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int n = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic [n-1:0]   a0,
  input  logic [n-1:0]   b0,
  input  logic           req1,
  input  logic [n-1:0]   a1,
  input  logic [n-1:0]   b1,
  output logic           done0,
  output logic           done1,
  output logic [2*n-1:0] z,
  output logic           busy
);

  state_e         state_q;
  logic [n-1:0]   op_a_q;
  logic [n-1:0]   op_b_q;
  logic           gnt_q;
  logic           last_grant_q;
  logic [2*n-1:0] z_q;
  logic           done0_q;
  logic           done1_q;
  logic           busy_q;

  logic           grant_d;
  logic [2*n-1:0] mul_z;

  always_comb begin
    grant_d = pick_grant(req0, req1, last_grant_q);
  end

  multiplyOperator #(.n(n)) u_mul (
    .A (op_a_q),
    .B (op_b_q),
    .Z (mul_z)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      gnt_q        <= GNT0;
      last_grant_q <= GNT1;
      z_q          <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req0 || req1) begin
            gnt_q        <= grant_d;
            last_grant_q <= grant_d;
            op_a_q       <= (grant_d == GNT1) ? a1 : a0;
            op_b_q       <= (grant_d == GNT1) ? b1 : b0;
            state_q      <= ST_MUL;
            busy_q       <= 1'b1;
          end
        end
        ST_MUL: begin
          z_q     <= mul_z;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          // Requests are ignored here; the pulse appears as we return to IDLE.
          done0_q <= (gnt_q == GNT0);
          done1_q <= (gnt_q == GNT1);
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign done0 = done0_q;
  assign done1 = done1_q;
  assign z     = z_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench: expected (requester, product) pairs are queued when a
// request is driven and compared against each done pulse.
module tb_mult_share_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [N-1:0] a0, b0, a1, b1;
  logic         done0, done1, busy;
  logic [2*N-1:0] z;

  typedef struct {
    logic       id;
    logic [7:0] zv;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.n(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .a0    (a0),
    .b0    (b0),
    .req1  (req1),
    .a1    (a1),
    .b1    (b1),
    .done0 (done0),
    .done1 (done1),
    .z     (z),
    .busy  (busy)
  );

  // Waits (bounded) for the next done pulse; returns at the negedge where it is seen.
  task automatic wait_done(input int budget, output logic ok, output logic id,
                           output logic [7:0] zv, output int edges, output int busy_cnt);
    ok = 1'b0; id = 1'b0; zv = '0; edges = 0; busy_cnt = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done0 || done1) begin
        ok = 1'b1;
        id = done1;
        zv = z;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({done0, done1, busy, z} !== 11'd0) begin
        errors++;
        $display("FAIL reset_state cycle %0d: done0=%b done1=%b busy=%b z=%0d want all 0",
                 i, done0, done1, busy, z);
      end
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({done0, done1, busy, z} !== 11'd0) begin
        errors++;
        $display("FAIL idle_state: done0=%b done1=%b busy=%b z=%0d want all 0", done0, done1, busy, z);
      end
    end
  endtask

  task automatic test_single;
    logic ok, id; logic [7:0] zv; int edges, bc; exp_t e;
    @(negedge clk);
    req0 = 1; a0 = 4'd15; b0 = 4'd5;
    sb.push_back('{1'b0, 8'd75});
    wait_done(10, ok, id, zv, edges, bc);
    req0 = 0;
    e = sb.pop_front();
    checks++;
    if (!ok || id !== e.id || zv !== e.zv || done1 !== 1'b0) begin
      errors++;
      $display("FAIL single_result: ok=%b id=%b z=%0d done1=%b want id=%b z=%0d", ok, id, zv, done1, e.id, e.zv);
    end
    $display("txn single: id=%b z=%0d edges=%0d", id, zv, edges);
    checks++;
    if (edges !== 3) begin
      errors++;
      $display("FAIL single_latency: edges=%0d want 3", edges);
    end
    checks++;
    if (bc !== 2) begin
      errors++;
      $display("FAIL single_busy: busy cycles=%0d want 2", bc);
    end
  endtask

  task automatic test_alternate;
    logic ok, id; logic [7:0] zv; int edges, bc; exp_t e;
    do_reset(2);
    req0 = 1; a0 = 4'd12; b0 = 4'd15;
    req1 = 1; a1 = 4'd12; b1 = 4'd3;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{1'b0, 8'd180});
      sb.push_back('{1'b1, 8'd36});
    end
    for (int k = 0; k < 4; k++) begin
      wait_done(10, ok, id, zv, edges, bc);
      if (k == 3) begin req0 = 0; req1 = 0; end
      e = sb.pop_front();
      $display("txn alternate %0d: id=%b z=%0d edges=%0d", k, id, zv, edges);
      checks++;
      if (!ok || id !== e.id || zv !== e.zv || (done0 & done1)) begin
        errors++;
        $display("FAIL alternate_%0d: ok=%b id=%b z=%0d want id=%b z=%0d", k, ok, id, zv, e.id, e.zv);
      end
      checks++;
      if (edges !== 3) begin
        errors++;
        $display("FAIL alternate_spacing_%0d: edges=%0d want 3", k, edges);
      end
    end
  endtask

  task automatic test_late_arrival;
    logic ok, id; logic [7:0] zv; int edges, bc; exp_t e;
    @(negedge clk);
    req0 = 1; a0 = 4'd12; b0 = 4'd10;
    sb.push_back('{1'b0, 8'd120});
    @(negedge clk);
    req1 = 1; a1 = 4'd0; b1 = 4'd0;
    sb.push_back('{1'b1, 8'd0});
    for (int k = 0; k < 2; k++) begin
      wait_done(10, ok, id, zv, edges, bc);
      if (id) req1 = 0; else req0 = 0;
      e = sb.pop_front();
      $display("txn late %0d: id=%b z=%0d", k, id, zv);
      checks++;
      if (!ok || id !== e.id || zv !== e.zv) begin
        errors++;
        $display("FAIL late_arrival_%0d: ok=%b id=%b z=%0d want id=%b z=%0d", k, ok, id, zv, e.id, e.zv);
      end
    end
    req0 = 0; req1 = 0;
  endtask

  task automatic test_reset_mid_op;
    logic ok, id; logic [7:0] zv; int edges, bc; exp_t e;
    logic saw_done;
    @(negedge clk);
    req1 = 1; a1 = 4'd15; b1 = 4'd15;
    @(negedge clk);
    rst = 1'b1; req1 = 0;
    @(negedge clk);
    checks++;
    if ({done0, done1, busy, z} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid_op: done0=%b done1=%b busy=%b z=%0d want all 0", done0, done1, busy, z);
    end
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done0 || done1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: done pulse after reset, want none");
    end
    req1 = 1;
    sb.push_back('{1'b1, 8'd225});
    wait_done(10, ok, id, zv, edges, bc);
    req1 = 0;
    e = sb.pop_front();
    $display("txn rerequest: id=%b z=%0d", id, zv);
    checks++;
    if (!ok || id !== e.id || zv !== e.zv) begin
      errors++;
      $display("FAIL rerequest: ok=%b id=%b z=%0d want id=%b z=%0d", ok, id, zv, e.id, e.zv);
    end
  endtask

  task automatic test_operand_stability;
    logic ok, id; logic [7:0] zv; int edges, bc; exp_t e;
    @(negedge clk);
    req0 = 1; a0 = 4'd3; b0 = 4'd13;
    sb.push_back('{1'b0, 8'd39});
    @(posedge clk);
    #1 a0 = 4'd9;
    wait_done(10, ok, id, zv, edges, bc);
    req0 = 0;
    e = sb.pop_front();
    $display("txn stability: id=%b z=%0d", id, zv);
    checks++;
    if (!ok || id !== e.id || zv !== e.zv) begin
      errors++;
      $display("FAIL operand_stability: ok=%b id=%b z=%0d want id=%b z=%0d", ok, id, zv, e.id, e.zv);
    end
  endtask

  task automatic test_hold_after_done;
    repeat (3) @(negedge clk);
    checks++;
    if (z !== 8'd39 || busy !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL z_hold: z=%0d busy=%b done0=%b want z=39 busy=0 done0=0", z, busy, done0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_late_arrival();
    test_reset_mid_op();
    test_operand_stability();
    test_hold_after_done();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one combinational multiplyOperator instance between two requesters using round-robin arbitration and a req/done handshake.
- Operands and the product are registered, so the multiplier sits between two register stages.
- Sits between the two client blocks and the multiplier datapath in the multiplication subsystem.

Parameters:
- n, 4, operand width in bits; the product width is 2*n.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 request; held high until done0 is seen.
- a0  input  n  requester 0 multiplicand; must be stable while req0 is high.
- b0  input  n  requester 0 multiplier; must be stable while req0 is high.
- req1  input  1  requester 1 request.
- a1  input  n  requester 1 multiplicand.
- b1  input  n  requester 1 multiplier.
- done0  output  1  one-cycle pulse: the product for requester 0 is valid on z.
- done1  output  1  one-cycle pulse: the product for requester 1 is valid on z.
- z  output  2n  shared product register; valid when done0 or done1 is high.
- busy  output  1  high while in MUL or DONE.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; done0=done1=0; busy=0; z=0.
  - Operand registers cleared.
  - last_grant=1, so requester 0 wins the first contention.
- FSM has three states: IDLE, MUL, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Only reqX high: grant X.
  - Both high: grant the requester not equal to last_grant.
  - On grant: latch aX/bX into op_a/op_b, set gnt=X, set last_grant=X, go to MUL.
- MUL (1 cycle):
  - multiplyOperator(A=op_a, B=op_b) drives its Z combinationally.
  - At the edge, Z is captured into z; go to DONE.
- DONE (1 cycle):
  - done[gnt]=1, the other done=0; z holds the product.
  - req inputs are ignored in this state. Next state is IDLE.
- Latency:
  - A request sampled at edge k (state IDLE) sees done high in the cycle after edge k+2.
  - Throughput is one product per 3 cycles.
- Handshake:
  - A requester drops req in the cycle after its done pulse.
  - If req is still high when IDLE resamples, it is a new request; round-robin then favours the other requester if it is pending.
- z holds its value after DONE until the next MUL capture. Consumers must qualify z with done.
- Width rule: the product is unsigned, full 2n bits, no truncation or overflow possible (e.g. n=4, max 15*15=225).
- Boundary cases:
  - Request arriving during MUL or DONE is not lost; it is served at the next IDLE.
  - Both requesters continuously high: grants strictly alternate 0,1,0,1,...
  - Reset mid-operation (MUL or DONE): the operation is aborted, no done pulse is generated, and the reset values above apply at the next cycle.
  - Operand changes while req is high but not yet granted have no effect; only values present at the grant edge are used.
  - Zero operands produce z=0 with a normal done pulse.

Decomposition:
- Shared package mult_share_pkg holds:
  - localparams for state encoding: IDLE=2'd0, MUL=2'd1, DONE=2'd2.
  - grant IDs: GNT0=1'b0, GNT1=1'b1.
- One sub-module: the existing multiplyOperator, instantiated once with #(.n(n)) on the registered operands.
- Arbitration and FSM logic stay in mult_share_arbiter.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no req -> z=0, done0=done1=0, busy=0 throughout.
- Single requester: req0=1, a0=4'b1111, b0=4'b0101 -> done0 pulses exactly 3 edges after the request edge, z=8'd75, done1 stays 0, busy high for 2 cycles.
- Simultaneous requests after reset:
  - Stimulus: req0 with 12*15, req1 with 12*3, both held.
  - Required: first done0 with z=8'd180, then done1 with z=8'd36 three cycles later.
  - Both requesters kept high afterwards: grants continue to alternate.
- Late arrival: req0 with 12*10 granted; req1 with 0*0 asserted during MUL -> done0 with z=8'd120, then done1 with z=8'd0, with no request lost.
- Reset mid-operation: req1 with 15*15, assert rst during MUL -> no done1 pulse, z=0. After release and re-request, done1 with z=8'd225.
- Operand stability: change a0 from 3 to 9 after the grant edge while req0 is high -> z reflects the latched value 3*b0, not 9*b0.
